ysyx_23060208_ifu: RTL
======================

// Module: ysyx_23060208_ifu
// PURPOSE
// - Instruction fetch unit directly upstream of ysyx_23060208_isram. Holds the PC,
//   issues one AXI-lite style read per instruction (AR then R channel), registers the
//   returned word and hands {pc, inst} to the IDU over a valid/allowin handshake.
// - Accepts a PC redirect (branch/jump/trap) from downstream. A redirect discards any
//   in-flight or held fetch.
// PARAMETERS
// - DATA_WIDTH  32            address/data width; only 32 is supported
// - RESET_PC    32'h8000_0000 PC loaded at reset
// PORTS
// - clk               in   1   clock
// - rst               in   1   reset; asynchronous, active-low (0 = reset)
// - isram_araddr      out  32  read address (= current fetch PC)
// - isram_arvalid     out  1   read request valid
// - isram_arready     in   1   isram accepts request
// - isram_rresp       in   2   read response; 2'b00 = OKAY, any other value = error
// - isram_rvalid      in   1   read data valid
// - isram_rdata       in   32  instruction word
// - isram_rready      out  1   IFU accepts read data
// - ifu_allowin       out  1   equal to isram_rready; drives isram ifu_allowin
// - ifu_to_idu_valid  out  1   {pc, inst, err} valid to IDU
// - ifu_to_idu_pc     out  32  PC of the held instruction
// - ifu_to_idu_inst   out  32  held instruction word
// - ifu_to_idu_err    out  1   held word had rresp != OKAY (or misaligned, see CONFIG)
// - idu_allowin       in   1   IDU accepts; handshake = ifu_to_idu_valid & idu_allowin
// - redirect_valid    in   1   one-cycle request to change the PC
// - redirect_pc       in   32  new fetch PC
// BEHAVIOUR
// - Reset values: arvalid=0, rready=0, ifu_to_idu_valid=0, inst=0, err=0,
//   araddr=RESET_PC, ifu_to_idu_pc=RESET_PC, discard=0, state=IDLE.
// - FSM: IDLE -> AR on the first clk edge after reset deasserts (unconditional).
//   AR:   arvalid=1, araddr=pc. On arvalid&arready -> R.
//   R:    rready=1. On rvalid: if discard then discard<=0 and go AR with pc = pending
//         redirect PC; else latch rdata/pc, err<=(rresp!=0), go HOLD.
//   HOLD: ifu_to_idu_valid=1. On handshake: pc<=pc+4 (wraps mod 2^32), go AR.
// - Each AXI output is registered. araddr is stable from arvalid rise until the AR
//   handshake. No rvalid is ignored in R. Exactly one read is outstanding at most.
// - Latency: AR handshake in cycle N, rvalid in cycle M>=N+1, ifu_to_idu_valid high
//   from cycle M+1. Back-to-back: handshake in HOLD gives arvalid the next cycle.
// - Redirect, by state. In every case redirect_pc is stored and the next AR uses it.
//   IDLE/HOLD: pc<=redirect_pc, valid drops next cycle, go AR.
//   AR not yet handshaken: keep araddr, set discard, continue the read.
//   R: set discard; the response is dropped.
//   Redirect coincident with the AR handshake or with rvalid: treat as in R (drop).
//   Redirect coincident with an IDU handshake: the transfer completes;
//   pc<=redirect_pc (not pc+4).
//   Redirect in the same cycle as a second redirect: the latest redirect_pc wins.
// - rresp error: inst is still presented, with err=1. The IFU never retries.
// - Reset asserted mid-transaction: all state returns to reset values immediately.
//   Any pending isram response is not tracked.
// CONFIGURATION
// - YSYX_23060208_IFU_ALIGN_CHECK_EN defined:
//   - If pc[1:0]!=0 when entering AR, no read is issued.
//   - Go straight to HOLD with inst=32'h0000_0013 (nop), err=1.
// - Macro undefined: pc[1:0] is ignored and the address is issued as-is.
// TESTING
// - Reset release, arready=1, rdata=32'h0000_0093 one cycle later ->
//   araddr=8000_0000, valid with pc=8000_0000, inst=0000_0093.
// - idu_allowin=0 for 5 cycles in HOLD -> valid/pc/inst stable, no arvalid.
//   Then allowin=1 -> next AR has araddr=8000_0004.
// - redirect_valid with pc 8000_0100 while in R ->
//   the returned word is never shown to the IDU; the next araddr is 8000_0100.
// - Redirect coincident with the IDU handshake ->
//   the held word transfers once; the next araddr is the redirect PC.
// - rresp=2'b10 on a fetch -> ifu_to_idu_err=1 with that word;
//   the next fetch returns err=0.
// - ALIGN_CHECK_EN, redirect to 8000_0102 -> no arvalid, inst=0000_0013, err=1.
//   Without the macro: araddr=8000_0102.

Source files
------------

// File: rtl/ysyx_23060208_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_23060208_ifu
//
// Instruction fetch unit sitting directly upstream of ysyx_23060208_isram.
// Holds the fetch PC, issues one AXI-lite style read per instruction (AR then
// R channel), registers the returned word and presents {pc, inst, err} to the
// IDU over a valid/allowin handshake. A redirect from downstream replaces the
// fetch PC and discards any in-flight or held fetch.
//
// Optional feature macro: YSYX_23060208_IFU_ALIGN_CHECK_EN
//   defined   : a fetch PC with pc[1:0] != 0 issues no read; a nop (0x00000013)
//               is presented with err=1 instead.
//   undefined : pc[1:0] is ignored and the address is issued as-is.
//
// Ports
//   clk                in   clock
//   rst                in   asynchronous active-low reset
//   isram_araddr       out  read address (current fetch PC)
//   isram_arvalid      out  read request valid
//   isram_arready      in   isram accepts request
//   isram_rresp        in   read response, 2'b00 = OKAY
//   isram_rvalid       in   read data valid
//   isram_rdata        in   instruction word
//   isram_rready       out  IFU accepts read data
//   ifu_allowin        out  mirror of isram_rready
//   ifu_to_idu_valid   out  held instruction valid
//   ifu_to_idu_pc      out  PC of held instruction
//   ifu_to_idu_inst    out  held instruction word
//   ifu_to_idu_err     out  held word returned an error response (or misaligned)
//   idu_allowin        in   IDU accepts the held instruction
//   redirect_valid     in   one-cycle PC change request
//   redirect_pc        in   new fetch PC
//
// States
//   state  | meaning
//   IDLE   | leaving reset, starts the first fetch on the next edge
//   AR     | read request presented, waiting for arready
//   R      | request accepted, waiting for rvalid
//   HOLD   | instruction presented to the IDU, waiting for the handshake
// ----------------------------------------------------------------------------
module ysyx_23060208_ifu #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,

    output logic [DATA_WIDTH-1:0] isram_araddr,
    output logic                  isram_arvalid,
    input  logic                  isram_arready,
    input  logic [1:0]            isram_rresp,
    input  logic                  isram_rvalid,
    input  logic [DATA_WIDTH-1:0] isram_rdata,
    output logic                  isram_rready,

    output logic                  ifu_allowin,
    output logic                  ifu_to_idu_valid,
    output logic [DATA_WIDTH-1:0] ifu_to_idu_pc,
    output logic [DATA_WIDTH-1:0] ifu_to_idu_inst,
    output logic                  ifu_to_idu_err,
    input  logic                  idu_allowin,

    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc
);

    localparam logic [DATA_WIDTH-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [DATA_WIDTH-1:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pend_pc;
    logic                  discard;

    logic                  idu_hs;
    logic                  fetch_req;
    logic [DATA_WIDTH-1:0] fetch_addr;
    logic                  misaligned;

    assign ifu_allowin = isram_rready;
    assign idu_hs      = ifu_to_idu_valid & idu_allowin;

    // Every path that starts a new fetch funnels through fetch_req/fetch_addr,
    // so the alignment check and the AR setup live in exactly one place.
    always_comb begin
        fetch_req  = 1'b0;
        fetch_addr = pc;
        case (state)
            S_IDLE: begin
                fetch_req  = 1'b1;
                fetch_addr = redirect_valid ? redirect_pc : pc;
            end
            S_R: begin
                // A redirect landing on the rvalid cycle drops the word just
                // like an earlier one would; the newest PC wins.
                if (isram_rvalid && (discard || redirect_valid)) begin
                    fetch_req  = 1'b1;
                    fetch_addr = redirect_valid ? redirect_pc : pend_pc;
                end
            end
            S_HOLD: begin
                // Redirect takes priority over the sequential pc+4 even when
                // the IDU handshake completes in the same cycle.
                if (redirect_valid) begin
                    fetch_req  = 1'b1;
                    fetch_addr = redirect_pc;
                end else if (idu_hs) begin
                    fetch_req  = 1'b1;
                    fetch_addr = pc + PC_STEP;
                end
            end
            default: begin
                fetch_req  = 1'b0;
                fetch_addr = pc;
            end
        endcase
    end

`ifdef YSYX_23060208_IFU_ALIGN_CHECK_EN
    assign misaligned = (fetch_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= S_IDLE;
            pc               <= RESET_PC;
            pend_pc          <= RESET_PC;
            discard          <= 1'b0;
            isram_araddr     <= RESET_PC;
            isram_arvalid    <= 1'b0;
            isram_rready     <= 1'b0;
            ifu_to_idu_valid <= 1'b0;
            ifu_to_idu_pc    <= RESET_PC;
            ifu_to_idu_inst  <= '0;
            ifu_to_idu_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Next state fully set by the fetch_req block below.
                end

                S_AR: begin
                    // araddr stays put so the outstanding request is not
                    // disturbed; the response will be thrown away.
                    if (redirect_valid) begin
                        discard <= 1'b1;
                        pend_pc <= redirect_pc;
                    end
                    if (isram_arready) begin
                        isram_arvalid <= 1'b0;
                        isram_rready  <= 1'b1;
                        state         <= S_R;
                    end
                end

                S_R: begin
                    if (isram_rvalid) begin
                        isram_rready <= 1'b0;
                        if (discard || redirect_valid) begin
                            discard <= 1'b0;
                        end else begin
                            ifu_to_idu_valid <= 1'b1;
                            ifu_to_idu_pc    <= pc;
                            ifu_to_idu_inst  <= isram_rdata;
                            ifu_to_idu_err   <= (isram_rresp != 2'b00);
                            state            <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        discard <= 1'b1;
                        pend_pc <= redirect_pc;
                    end
                end

                S_HOLD: begin
                    if (idu_hs || redirect_valid) begin
                        ifu_to_idu_valid <= 1'b0;
                    end
                end

                default: state <= S_IDLE;
            endcase

            // Launch the next fetch. Placed after the case so it overrides the
            // state/valid assignments made above.
            if (fetch_req) begin
                pc <= fetch_addr;
                if (misaligned) begin
                    isram_arvalid    <= 1'b0;
                    ifu_to_idu_valid <= 1'b1;
                    ifu_to_idu_pc    <= fetch_addr;
                    ifu_to_idu_inst  <= NOP_INST;
                    ifu_to_idu_err   <= 1'b1;
                    state            <= S_HOLD;
                end else begin
                    isram_arvalid <= 1'b1;
                    isram_araddr  <= fetch_addr;
                    state         <= S_AR;
                end
            end
        end
    end

endmodule
